// File: rtl/cpu_pkg.sv
// Shared CPU definitions: M-extension encodings and divider FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] DIV_F3  = 3'b100;
    localparam logic [2:0] DIVU_F3 = 3'b101;
    localparam logic [2:0] REM_F3  = 3'b110;
    localparam logic [2:0] REMU_F3 = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring step: shift {rem, quo} left, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;
    logic            fits;

    // Shift in the next dividend bit, keep the difference when the divisor fits.
    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        fits    = (shifted >= {2'b00, divisor_i});
        diff    = shifted[XLEN:0] - {1'b0, divisor_i};
        if (fits) begin
            rem_o = diff;
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/ex_divider.sv
// EX-stage iterative DIV/DIVU/REM/REMU unit, one quotient bit per cycle.
// Latency: 34 cycles start-to-result, 2 cycles for divide-by-zero / overflow.
// Backpressure: DivStalled holds F/D/E until the single-cycle div_valid.
module ex_divider
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_E,
    input  logic [2:0]      funct3_E,
    input  logic [XLEN-1:0] src_a_E,
    input  logic [XLEN-1:0] src_b_E,
    input  logic            kill,
    output logic            DivStalled,
    output logic [XLEN-1:0] div_result,
    output logic            div_valid
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic            is_rem_q, is_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_quo;

    logic            op_signed, op_rem, a_neg, b_neg, div_zero, overflow;
    logic [XLEN-1:0] mag_a, mag_b, fin_quo, fin_rem;

    div_iter_step #(.XLEN(XLEN)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Operand decode: signs, magnitudes and the two early-out cases.
    always_comb begin
        op_signed = (funct3_E == DIV_F3) || (funct3_E == REM_F3);
        op_rem    = (funct3_E == REM_F3) || (funct3_E == REMU_F3);
        a_neg     = op_signed & src_a_E[XLEN-1];
        b_neg     = op_signed & src_b_E[XLEN-1];
        mag_a     = a_neg ? (~src_a_E + 1'b1) : src_a_E;
        mag_b     = b_neg ? (~src_b_E + 1'b1) : src_b_E;
        div_zero  = (src_b_E == '0);
        overflow  = op_signed && (src_a_E == MIN_NEG) && (src_b_E == '1);
        fin_quo   = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        fin_rem   = neg_rem_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
    end

    // Next-state, datapath update and result registration.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        is_rem_d  = is_rem_q;
        result_d  = result_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (start_E && !kill) begin
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    is_rem_d  = op_rem;
                    rem_d     = '0;
                    quo_d     = mag_a;
                    dvs_d     = mag_b;
                    count_d   = CW'(XLEN - 1);
                    if (div_zero) begin
                        result_d = op_rem ? src_a_E : '1;
                        state_d  = DIV_DONE;
                    end else if (overflow) begin
                        result_d = op_rem ? '0 : MIN_NEG;
                        state_d  = DIV_DONE;
                    end else begin
                        state_d  = DIV_CALC;
                    end
                end
            end
            DIV_CALC: begin
                if (kill) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    if (count_q == '0) begin
                        result_d = is_rem_q ? fin_rem : fin_quo;
                        state_d  = DIV_DONE;
                    end else begin
                        count_d = count_q - 1'b1;
                    end
                end
            end
            DIV_DONE: begin
                // E advances at this edge, so a start seen now belongs to the old instruction.
                state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // State and datapath registers, all cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_rem_q  <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            is_rem_q  <= is_rem_d;
            result_q  <= result_d;
        end
    end

    // Stall is combinational from IDLE so the start cycle already holds the pipe.
    always_comb begin
        DivStalled = (((state_q == DIV_IDLE) && start_E) || (state_q == DIV_CALC)) && !kill;
        div_valid  = (state_q == DIV_DONE) && !kill;
        div_result = result_q;
    end

endmodule

// File: tb/tb_ex_divider.sv
// Self-checking bench for ex_divider: directed vectors, kill/reset sequences, random ops.
// Latency: checks 33-cycle stall / 34-cycle result and the 1-cycle special path.
// Backpressure: checks DivStalled and the single div_valid cycle.
module tb_ex_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_E;
    logic [2:0]  funct3_E;
    logic [31:0] src_a_E;
    logic [31:0] src_b_E;
    logic        kill;
    logic        DivStalled;
    logic [31:0] div_result;
    logic        div_valid;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    ex_divider #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_E    (start_E),
        .funct3_E   (funct3_E),
        .src_a_E    (src_a_E),
        .src_b_E    (src_b_E),
        .kill       (kill),
        .DivStalled (DivStalled),
        .div_result (div_result),
        .div_valid  (div_valid)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        bit          special;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Architectural RV32M result from plain arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        bit is_signed, is_rem;
        sa = a;
        sb = b;
        is_signed = (f3 == 3'b100) || (f3 == 3'b110);
        is_rem    = f3[1];
        if (b == 0)
            return is_rem ? a : 32'hFFFF_FFFF;
        if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return is_rem ? 32'h0 : 32'h8000_0000;
        if (is_signed)
            return is_rem ? 32'(sa % sb) : 32'(sa / sb);
        return is_rem ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Issue one op in the next cycle and follow it to its result.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input bit special, input string tag);
        int k;
        int stalls;
        bit got;
        int exp_lat;
        exp_lat = special ? 1 : 33;
        @(posedge clk); #1;
        kill = 1'b0; start_E = 1'b1; funct3_E = f3; src_a_E = a; src_b_E = b;
        @(negedge clk);
        chk({tag, " stall_c0"}, 32'(DivStalled), 32'd1);
        chk({tag, " valid_c0"}, 32'(div_valid), 32'd0);
        chk({tag, " held_result"}, div_result, last_res);
        stalls = 1;
        got = 1'b0;
        k = 0;
        while (!got && k < 100) begin
            k++;
            @(posedge clk); #1;
            start_E  = 1'b0;
            src_a_E  = $urandom;
            src_b_E  = $urandom;
            funct3_E = 3'($urandom);
            @(negedge clk);
            if (div_valid) begin
                got = 1'b1;
                chk({tag, " latency"}, 32'(k), 32'(exp_lat));
                chk({tag, " stall_done"}, 32'(DivStalled), 32'd0);
                chk({tag, " result"}, div_result, exp_res);
                last_res = exp_res;
            end else if (DivStalled) begin
                stalls++;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: no div_valid within 100 cycles", tag);
        end
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(exp_lat == 1 ? 1 : 33));
    endtask

    vec_t vecs[$];

    initial begin
        logic [2:0]  f3;
        logic [31:0] a, b;
        int          sel;

        vecs.push_back('{3'b101, 32'd100, 32'd7, 32'd14, 1'b0});
        vecs.push_back('{3'b111, 32'd100, 32'd7, 32'd2, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0});
        vecs.push_back('{3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{3'b111, 32'd5, 32'd0, 32'd5, 1'b1});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1'b1});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b1});
        vecs.push_back('{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0});

        rst = 1'b1; start_E = 1'b0; kill = 1'b0; funct3_E = 3'b0; src_a_E = '0; src_b_E = '0;
        repeat (2) @(negedge clk);
        chk("reset stall", 32'(DivStalled), 32'd0);
        chk("reset valid", 32'(div_valid), 32'd0);
        chk("reset result", div_result, 32'd0);
        rst = 1'b0;

        foreach (vecs[i])
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].special,
                   $sformatf("vec%0d", i));

        // Kill in CALC cycle 10, then restart immediately.
        @(posedge clk); #1;
        start_E = 1'b1; funct3_E = 3'b101; src_a_E = 32'd1000; src_b_E = 32'd7;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start_E = 1'b0;
            if (c == 10) kill = 1'b1;
            @(negedge clk);
            if (c == 9) chk("kill pre stall", 32'(DivStalled), 32'd1);
        end
        chk("kill stall", 32'(DivStalled), 32'd0);
        chk("kill valid", 32'(div_valid), 32'd0);
        run_op(3'b101, 32'd1000, 32'd7, 32'd142, 1'b0, "after_kill");

        // Asynchronous reset in the middle of CALC.
        @(posedge clk); #1;
        start_E = 1'b1; funct3_E = 3'b101; src_a_E = 32'd12345; src_b_E = 32'd11;
        repeat (5) begin
            @(posedge clk); #1;
            start_E = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        chk("arst stall", 32'(DivStalled), 32'd0);
        chk("arst valid", 32'(div_valid), 32'd0);
        chk("arst result", div_result, 32'd0);
        last_res = '0;
        @(negedge clk);
        rst = 1'b0;
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0, "post_rst");
        run_op(3'b101, 32'd9, 32'd3, 32'd3, 1'b0, "b2b");

        // Random ops against the arithmetic model, biased toward corner operands.
        for (int r = 0; r < 40; r++) begin
            f3  = 3'b100 | 3'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = (sel < 5) ? $urandom : 32'($urandom_range(0, 300));
            if (sel == 0) b = 32'd0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            run_op(f3, a, b, ref_model(f3, a, b), is_special(f3, a, b), $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_divider.md
# ex_divider

Iterative RV32M divide/remainder unit in the EX stage of the pipelined CPU. It accepts DIV, DIVU, REM and REMU operands from the EX stage and computes one quotient bit per cycle with a radix-2 restoring algorithm. While it works it drives `DivStalled` to the hazard detection unit, which holds F/D/E stalled. It presents the result for exactly one cycle, in which the pipeline advances.

## Interface
- `XLEN`, 32: operand/result width.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_E` in 1: EX holds a valid M-extension divide-class instruction (opcode 0110011, funct7 0000001, funct3[2]=1).
- `funct3_E` in 3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `src_a_E` in XLEN: dividend, post-forwarding.
- `src_b_E` in XLEN: divisor, post-forwarding.
- `kill` in 1: abort the in-flight operation (E flush or trap).
- `DivStalled` out 1: stall request to the hazard unit.
- `div_result` out XLEN: quotient or remainder, valid only with `div_valid`.
- `div_valid` out 1: result valid this cycle, for the EX→M result mux.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE, `start_E`=1, `kill`=0:
  - Capture sign flags and operand magnitudes as XLEN-bit unsigned values; |−2^31| = 0x80000000 fits.
  - Zero the (XLEN+1)-bit partial remainder and load `count`=XLEN−1.
  - Divisor zero or signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF): load the special result and go to DONE.
  - Otherwise go to CALC.
- CALC, each cycle:
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor from the upper bits.
  - If the result is non-negative, keep the difference and set quo[0]=1.
  - After `count`=0, apply sign correction, register `div_result`, and go to DONE.
- Sign rules:
  - Signed ops: quotient negated when the operand signs differ; remainder takes the dividend's sign.
  - Unsigned ops: no correction.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF, remainder = dividend.
  - Overflow: quotient 0x80000000, remainder 0.
- DONE: `div_valid`=1, `DivStalled`=0. The next state is always IDLE, and `start_E` is ignored this cycle (E advances at this edge).
- `DivStalled` = (IDLE & `start_E` & ~`kill`) | CALC. It is combinational from IDLE so the first cycle already stalls.
- `kill` in any state: next state IDLE, `DivStalled` low in the same cycle, no `div_valid`.
- `rst` asserted at any time: state IDLE, `count`=0, `div_result`=0, `div_valid`=0, `DivStalled`=0, datapath registers cleared. Reset wins over `kill` and `start_E`.

## Timing
- Normal op, start seen in cycle 0:
  - `DivStalled` high cycles 0–32 (33 cycles); CALC covers cycles 1–32.
  - DONE in cycle 33: `div_valid`=1 and `DivStalled`=0.
  - Total latency 34 cycles from the start cycle to the result.
- Special case: `DivStalled` high in cycle 0 only; DONE in cycle 1.
- Back-to-back divides: the second starts in the cycle after DONE. There are no idle bubbles beyond DONE.
- Operands are sampled only in the IDLE start cycle. Later changes on `src_*_E` (forwarding settling) are ignored.
- `div_result` is held stable from DONE until the next result is registered.

## Structure
- Shared package `cpu_pkg`:
  - `DIV_F3`/`DIVU_F3`/`REM_F3`/`REMU_F3` constants.
  - M-extension funct7 and OP opcode constants.
  - Divider state enum.
- One sub-module: `div_iter_step`, combinational shift + trial-subtract, inputs {rem, quo, divisor}, outputs next {rem, quo}.
- Top level holds the FSM, counter, sign logic and special-case detection.

## Test plan
- DIVU 100/7: `DivStalled` high 33 cycles, then one cycle `div_valid`=1 with result 14. REMU with the same operands returns 2.
- DIV −7/2 → 0xFFFFFFFD (−3); REM −7/2 → 0xFFFFFFFF (−1); REM 7/−2 → 1.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with a 1-cycle stall and DONE in cycle 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0; special-case latency as above.
- `kill` asserted in CALC cycle 10: `DivStalled` low the same cycle, no `div_valid`. A new `start_E` next cycle runs the full 34 cycles and returns the correct result.
- `rst` pulsed asynchronously mid-CALC: all outputs go to 0 immediately. After release, DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF, then a back-to-back DIVU 9/3 → 3 starting the cycle after DONE.
